// File: rtl/jls_pkg.sv
// Shared types and constants for the JPEG-LS context-modelling stage:
// default thresholds, gradient width, Qi / context-index types and the sign-merge helper.
package jls_pkg;

  localparam int DEF_DW  = 16;
  localparam int DEF_T1  = 3;
  localparam int DEF_T2  = 7;
  localparam int DEF_T3  = 21;
  localparam int GRAD_W  = DEF_DW + 1;
  localparam int CTX_MAX = 364;

  typedef logic signed [3:0] qi_t;
  typedef logic [8:0]        ctx_t;

  typedef struct packed {
    ctx_t q;
    logic sign;
    logic run;
  } ctx_res_t;

  // Flip the triple so its first nonzero element is positive, then fold it into 0..CTX_MAX.
  function automatic ctx_res_t merge_ctx(input qi_t q1, input qi_t q2, input qi_t q3);
    ctx_res_t res;
    logic     neg;
    qi_t      m1, m2, m3;
    int       idx;
    neg = (q1 < 0) || (q1 == 0 && q2 < 0) || (q1 == 0 && q2 == 0 && q3 < 0);
    m1  = neg ? -q1 : q1;
    m2  = neg ? -q2 : q2;
    m3  = neg ? -q3 : q3;
    idx = 81 * int'(m1) + 9 * int'(m2) + int'(m3);
    res.q    = idx[8:0];
    res.sign = neg;
    res.run  = (q1 == 0) && (q2 == 0) && (q3 == 0);
    return res;
  endfunction

endpackage

// File: rtl/jls_grad_quant.sv
// Registered quantiser mapping one signed local gradient Di onto Qi in -4..4.
// Optional macro JLS_NEAR_EN widens the zero band to -NEAR..NEAR for near-lossless coding.
module jls_grad_quant
  import jls_pkg::*;
#(
  parameter int GW   = GRAD_W,
  parameter int T1   = DEF_T1,
  parameter int T2   = DEF_T2,
  parameter int T3   = DEF_T3
`ifdef JLS_NEAR_EN
  ,parameter int NEAR = 0
`endif
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic signed [GW-1:0] d,
  output qi_t                  q
);

  int  dv;
  qi_t q_next;

  // NOTE: every variable written in always_comb gets a value on every path,
  // otherwise synthesis infers a latch to hold the missing case.
  always_comb begin
    dv     = int'(d);
    q_next = qi_t'(0);
    if (dv <= -T3)       q_next = qi_t'(-4);
    else if (dv <= -T2)  q_next = qi_t'(-3);
    else if (dv <= -T1)  q_next = qi_t'(-2);
`ifdef JLS_NEAR_EN
    else if (dv < -NEAR) q_next = qi_t'(-1);
    else if (dv <= NEAR) q_next = qi_t'(0);
`else
    else if (dv < 0)     q_next = qi_t'(-1);
    else if (dv == 0)    q_next = qi_t'(0);
`endif
    else if (dv < T1)    q_next = qi_t'(1);
    else if (dv < T2)    q_next = qi_t'(2);
    else if (dv < T3)    q_next = qi_t'(3);
    else                 q_next = qi_t'(4);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst)     q <= qi_t'(0);
    else if (en) q <= q_next;
  end

endmodule

// File: rtl/jls_context_quant.sv
// JPEG-LS context quantiser: gradients, context index Q, run-mode flag and MED prediction,
// 3-stage pipeline with valid tagging. Optional macro JLS_NEAR_EN adds parameter NEAR.
module jls_context_quant
  import jls_pkg::*;
#(
  parameter int DW   = DEF_DW,
  parameter int T1   = DEF_T1,
  parameter int T2   = DEF_T2,
  parameter int T3   = DEF_T3
`ifdef JLS_NEAR_EN
  ,parameter int NEAR = 0
`endif
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_en,
  input  logic [DW-1:0] Ra,
  input  logic [DW-1:0] Rb,
  input  logic [DW-1:0] Rc,
  input  logic [DW-1:0] Rd,
  input  logic [DW-1:0] Ix,
  output logic          out_en,
  output ctx_t          Q,
  output logic          sign,
  output logic          run_mode,
  output logic [DW-1:0] Px,
  output logic [DW-1:0] Ix_o,
  output logic [DW-1:0] Ra_o
);

  localparam int GW = DW + 1;

  // ---------------- stage 1: gradients and MED comparisons ----------------
  logic                 v1;
  logic signed [GW-1:0] d1_r, d2_r, d3_r;
  logic                 ge_max_r, le_min_r;
  logic [DW-1:0]        mx_r, mn_r, ra1, rb1, rc1, ix1;
  logic [DW-1:0]        mx, mn;

  assign mx = (Ra > Rb) ? Ra : Rb;
  assign mn = (Ra > Rb) ? Rb : Ra;

  // NOTE: every pipeline register, data included, is cleared by rst so the
  // outputs read 0 right after reset rather than stale pixel values.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1       <= 1'b0;
      d1_r     <= '0;
      d2_r     <= '0;
      d3_r     <= '0;
      ge_max_r <= 1'b0;
      le_min_r <= 1'b0;
      mx_r     <= '0;
      mn_r     <= '0;
      ra1      <= '0;
      rb1      <= '0;
      rc1      <= '0;
      ix1      <= '0;
    end else begin
      v1 <= in_en;
      if (in_en) begin
        // Zero-extended by one bit so 0 - (2^DW-1) cannot wrap.
        d1_r     <= $signed({1'b0, Rd}) - $signed({1'b0, Rb});
        d2_r     <= $signed({1'b0, Rb}) - $signed({1'b0, Rc});
        d3_r     <= $signed({1'b0, Rc}) - $signed({1'b0, Ra});
        ge_max_r <= (Rc >= mx);
        le_min_r <= (Rc <= mn);
        mx_r     <= mx;
        mn_r     <= mn;
        ra1      <= Ra;
        rb1      <= Rb;
        rc1      <= Rc;
        ix1      <= Ix;
      end
    end
  end

  // ---------------- stage 2: quantisation and MED select ----------------
  logic          v2;
  qi_t           q1, q2, q3;
  logic [DW-1:0] px2, ix2, ra2, px_next;
  logic [DW+1:0] lin;

  jls_grad_quant #(
    .GW(GW), .T1(T1), .T2(T2), .T3(T3)
`ifdef JLS_NEAR_EN
    ,.NEAR(NEAR)
`endif
  ) u_q1 (.clk(clk), .rst(rst), .en(v1), .d(d1_r), .q(q1));

  jls_grad_quant #(
    .GW(GW), .T1(T1), .T2(T2), .T3(T3)
`ifdef JLS_NEAR_EN
    ,.NEAR(NEAR)
`endif
  ) u_q2 (.clk(clk), .rst(rst), .en(v1), .d(d2_r), .q(q2));

  jls_grad_quant #(
    .GW(GW), .T1(T1), .T2(T2), .T3(T3)
`ifdef JLS_NEAR_EN
    ,.NEAR(NEAR)
`endif
  ) u_q3 (.clk(clk), .rst(rst), .en(v1), .d(d3_r), .q(q3));

  // The planar case lands inside [min, max], so the truncation is exact.
  always_comb begin
    lin     = {2'b00, ra1} + {2'b00, rb1} - {2'b00, rc1};
    px_next = lin[DW-1:0];
    if (ge_max_r)      px_next = mn_r;
    else if (le_min_r) px_next = mx_r;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v2  <= 1'b0;
      px2 <= '0;
      ix2 <= '0;
      ra2 <= '0;
    end else begin
      v2 <= v1;
      if (v1) begin
        px2 <= px_next;
        ix2 <= ix1;
        ra2 <= ra1;
      end
    end
  end

  // ---------------- stage 3: sign merge and context index ----------------
  ctx_res_t res;

  assign res = merge_ctx(q1, q2, q3);

  always_ff @(posedge clk) begin
    if (rst) begin
      out_en   <= 1'b0;
      Q        <= '0;
      sign     <= 1'b0;
      run_mode <= 1'b0;
      Px       <= '0;
      Ix_o     <= '0;
      Ra_o     <= '0;
    end else begin
      out_en <= v2;
      if (v2) begin
        Q        <= res.q;
        sign     <= res.sign;
        run_mode <= res.run;
        Px       <= px2;
        Ix_o     <= ix2;
        Ra_o     <= ra2;
      end
    end
  end

endmodule

// File: tb/tb_jls_context_quant.sv
// Self-checking bench for jls_context_quant: directed vector table, gap/reset
// sequences and a random back-to-back run against a behavioural model.
module tb_jls_context_quant;

  localparam int DW = 16;
  localparam int T1 = 3;
  localparam int T2 = 7;
  localparam int T3 = 21;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_en;
  logic [DW-1:0] Ra, Rb, Rc, Rd, Ix;
  logic          out_en;
  logic [8:0]    Q;
  logic          sign;
  logic          run_mode;
  logic [DW-1:0] Px, Ix_o, Ra_o;

  jls_context_quant dut (
    .clk(clk), .rst(rst), .in_en(in_en),
    .Ra(Ra), .Rb(Rb), .Rc(Rc), .Rd(Rd), .Ix(Ix),
    .out_en(out_en), .Q(Q), .sign(sign), .run_mode(run_mode),
    .Px(Px), .Ix_o(Ix_o), .Ra_o(Ra_o)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Inputs change and outputs are read 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic en, input int a, input int b, input int c, input int d, input int x);
    in_en = en;
    Ra = DW'(a); Rb = DW'(b); Rc = DW'(c); Rd = DW'(d); Ix = DW'(x);
  endtask

  typedef struct {
    int q;
    logic sg;
    logic rm;
    int px;
  } exp_t;

  function automatic int qz(input int d);
    if (d <= -T3) return -4;
    if (d <= -T2) return -3;
    if (d <= -T1) return -2;
    if (d < 0)    return -1;
    if (d == 0)   return 0;
    if (d < T1)   return 1;
    if (d < T2)   return 2;
    if (d < T3)   return 3;
    return 4;
  endfunction

  function automatic exp_t model(input int a, input int b, input int c, input int d);
    exp_t e;
    int g1, g2, g3, hi, lo;
    g1 = qz(d - b);
    g2 = qz(b - c);
    g3 = qz(c - a);
    e.rm = (g1 == 0 && g2 == 0 && g3 == 0);
    e.sg = 1'b0;
    if (g1 < 0 || (g1 == 0 && g2 < 0) || (g1 == 0 && g2 == 0 && g3 < 0)) begin
      e.sg = 1'b1;
      g1 = -g1; g2 = -g2; g3 = -g3;
    end
    e.q = 81 * g1 + 9 * g2 + g3;
    hi = (a > b) ? a : b;
    lo = (a > b) ? b : a;
    if (c >= hi)      e.px = lo;
    else if (c <= lo) e.px = hi;
    else              e.px = a + b - c;
    return e;
  endfunction

  typedef struct {
    string name;
    int ra, rb, rc, rd, ix;
    int q;
    logic sg, rm;
    int px;
  } vec_t;

  typedef struct {
    exp_t e;
    int ix;
    int ra;
  } sb_t;

  vec_t vecs[14];
  sb_t  sbq[$];

  initial begin
    vecs[0]  = '{"flat",     100, 100, 100, 100, 1234, 0,   1'b0, 1'b1, 100};
    vecs[1]  = '{"mixed",    10,  20,  5,   50,  7,    349, 1'b0, 1'b0, 20};
    vecs[2]  = '{"negd1",    10,  10,  10,  0,   8,    243, 1'b1, 1'b0, 10};
    vecs[3]  = '{"sweep1",   0,   0,   0,   1,   11,   81,  1'b0, 1'b0, 0};
    vecs[4]  = '{"sweep2",   0,   0,   0,   2,   12,   81,  1'b0, 1'b0, 0};
    vecs[5]  = '{"sweep3",   0,   0,   0,   3,   13,   162, 1'b0, 1'b0, 0};
    vecs[6]  = '{"sweep6",   0,   0,   0,   6,   14,   162, 1'b0, 1'b0, 0};
    vecs[7]  = '{"sweep7",   0,   0,   0,   7,   15,   243, 1'b0, 1'b0, 0};
    vecs[8]  = '{"sweep20",  0,   0,   0,   20,  16,   243, 1'b0, 1'b0, 0};
    vecs[9]  = '{"sweep21",  0,   0,   0,   21,  17,   324, 1'b0, 1'b0, 0};
    vecs[10] = '{"sweepmax", 0,   0,   0,   65535, 18, 324, 1'b0, 1'b0, 0};
    vecs[11] = '{"medmid",   10,  30,  20,  20,  19,   213, 1'b1, 1'b0, 20};
    vecs[12] = '{"extlo",    0,   65535, 0, 0,   20,   288, 1'b1, 1'b0, 65535};
    vecs[13] = '{"exthi",    65535, 0, 65535, 65535, 21, 288, 1'b0, 1'b0, 0};

    rst = 1'b1;
    drive(1'b0, 0, 0, 0, 0, 0);
    step();
    step();
    check("rst_out_en", 32'(out_en), 0);
    check("rst_Q", 32'(Q), 0);
    check("rst_Px", 32'(Px), 0);
    check("rst_Ix_o", 32'(Ix_o), 0);
    rst = 1'b0;

    // Single-pulse vectors: out_en rises on the third edge after the pulse.
    foreach (vecs[i]) begin
      drive(1'b1, vecs[i].ra, vecs[i].rb, vecs[i].rc, vecs[i].rd, vecs[i].ix);
      step();
      in_en = 1'b0;
      step();
      check({vecs[i].name, "_early"}, 32'(out_en), 0);
      step();
      check({vecs[i].name, "_out_en"}, 32'(out_en), 1);
      check({vecs[i].name, "_Q"}, 32'(Q), 32'(vecs[i].q));
      check({vecs[i].name, "_sign"}, 32'(sign), 32'(vecs[i].sg));
      check({vecs[i].name, "_run"}, 32'(run_mode), 32'(vecs[i].rm));
      check({vecs[i].name, "_Px"}, 32'(Px), 32'(vecs[i].px));
      check({vecs[i].name, "_Ix_o"}, 32'(Ix_o), 32'(vecs[i].ix));
      check({vecs[i].name, "_Ra_o"}, 32'(Ra_o), 32'(vecs[i].ra));
      step();
      check({vecs[i].name, "_drop"}, 32'(out_en), 0);
    end

    // Gap pattern must reappear on out_en, each pixel carrying its own Ix.
    begin
      logic pat[6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
      for (int p = 0; p < 9; p++) begin
        if (p < 6) drive(pat[p], 5, 6, 7, 8, 200 + p);
        else       in_en = 1'b0;
        step();
        if (p >= 2 && p - 2 < 6) begin
          check($sformatf("gap_out_en%0d", p - 2), 32'(out_en), 32'(pat[p - 2]));
          if (pat[p - 2]) check($sformatf("gap_Ix%0d", p - 2), 32'(Ix_o), 32'(200 + p - 2));
        end else begin
          check($sformatf("gap_idle%0d", p), 32'(out_en), 0);
        end
      end
    end

    // Two pixels in flight, then rst with in_en high: nothing may emerge.
    drive(1'b1, 10, 20, 5, 50, 301);
    step();
    drive(1'b1, 10, 10, 10, 0, 302);
    step();
    rst = 1'b1;
    drive(1'b1, 10, 20, 5, 50, 303);
    step();
    rst = 1'b0;
    in_en = 1'b0;
    check("inflight_out_en", 32'(out_en), 0);
    check("inflight_Q", 32'(Q), 0);
    check("inflight_sign", 32'(sign), 0);
    check("inflight_run", 32'(run_mode), 0);
    check("inflight_Px", 32'(Px), 0);
    check("inflight_Ix_o", 32'(Ix_o), 0);
    check("inflight_Ra_o", 32'(Ra_o), 0);
    for (int k = 0; k < 4; k++) begin
      step();
      check($sformatf("inflight_stale%0d", k), 32'(out_en), 0);
    end

    // Back-to-back random 8-bit neighbours, extremes mixed in.
    begin
      int got = 0;
      int v[5];
      sb_t s, r;
      for (int n = 0; n < 10000; n++) begin
        for (int j = 0; j < 5; j++) begin
          int sel = int'($urandom_range(0, 9));
          if (sel == 0)      v[j] = 0;
          else if (sel == 1) v[j] = 255;
          else               v[j] = int'($urandom_range(0, 255));
        end
        s.e  = model(v[0], v[1], v[2], v[3]);
        s.ix = v[4];
        s.ra = v[0];
        sbq.push_back(s);
        drive(1'b1, v[0], v[1], v[2], v[3], v[4]);
        step();
        if (out_en) begin
          if (sbq.size() == 0) begin
            check("rand_unexpected", 32'(out_en), 0);
          end else begin
            r = sbq.pop_front();
            got++;
            check("rand_Q", 32'(Q), 32'(r.e.q));
            check("rand_sign", 32'(sign), 32'(r.e.sg));
            check("rand_run", 32'(run_mode), 32'(r.e.rm));
            check("rand_Px", 32'(Px), 32'(r.e.px));
            check("rand_Ix_o", 32'(Ix_o), 32'(r.ix));
            check("rand_Ra_o", 32'(Ra_o), 32'(r.ra));
          end
        end
      end
      in_en = 1'b0;
      for (int k = 0; k < 8; k++) begin
        step();
        if (out_en && sbq.size() != 0) begin
          r = sbq.pop_front();
          got++;
          check("rand_Q", 32'(Q), 32'(r.e.q));
          check("rand_sign", 32'(sign), 32'(r.e.sg));
          check("rand_run", 32'(run_mode), 32'(r.e.rm));
          check("rand_Px", 32'(Px), 32'(r.e.px));
          check("rand_Ix_o", 32'(Ix_o), 32'(r.ix));
          check("rand_Ra_o", 32'(Ra_o), 32'(r.ra));
        end
      end
      check("rand_count", 32'(got), 10000);
      check("rand_left", 32'(sbq.size()), 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
